// File: rtl/gcm_aes_input_sequencer.sv
// Sequences one GCM instance into the core: captures key/IV/sizes, then
// forwards AAD blocks followed by plaintext blocks with per-block flags.
module gcm_aes_input_sequencer #(
   parameter int unsigned SIZE_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [0:127]      cfg_key,
   input  logic [0:95]       cfg_iv,
   input  logic [0:SIZE_W-1] cfg_aad_blocks,
   input  logic [0:SIZE_W-1] cfg_pt_blocks,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:127]      in_data,
   output logic              o_valid,
   output logic              o_new_instance,
   output logic              o_pt_instance,
   output logic [0:127]      o_cipher_key,
   output logic [0:95]       o_iv,
   output logic [0:127]      o_aad,
   output logic [0:127]      o_plain_text,
   output logic [0:SIZE_W-1] o_aad_size,
   output logic [0:SIZE_W-1] o_plain_text_size,
   output logic              o_instance_done
);

   localparam int unsigned BLK_W = 128;
   localparam int unsigned IV_W  = 96;

   typedef enum logic [1:0] {S_IDLE, S_AAD, S_PT, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [SIZE_W-1:0]  r_aad_cnt, w_aad_cnt_nxt;
   logic [SIZE_W-1:0]  r_pt_cnt, w_pt_cnt_nxt;
   logic               r_first, w_first_nxt;
   logic               r_valid, w_valid_nxt;
   logic               r_new, w_new_nxt;
   logic               r_pt, w_pt_nxt;
   logic [BLK_W-1:0]   r_aad, w_aad_nxt;
   logic [BLK_W-1:0]   r_plain, w_plain_nxt;
   logic               r_done, w_done_nxt;
   logic [BLK_W-1:0]   r_key;
   logic [IV_W-1:0]    r_iv;
   logic [SIZE_W-1:0]  r_aad_size;
   logic [SIZE_W-1:0]  r_pt_size;
   logic               w_cfg_fire;

   assign cfg_ready  = (r_state == S_IDLE) && !rst;
   assign in_ready   = (r_state == S_AAD) || (r_state == S_PT);
   assign w_cfg_fire = cfg_valid && (r_state == S_IDLE);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_aad_cnt_nxt = r_aad_cnt;
      w_pt_cnt_nxt  = r_pt_cnt;
      w_first_nxt   = r_first;
      w_valid_nxt   = 1'b0;
      w_new_nxt     = 1'b0;
      w_pt_nxt      = 1'b0;
      w_aad_nxt     = '0;
      w_plain_nxt   = '0;
      w_done_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cfg_valid) begin
               w_aad_cnt_nxt = cfg_aad_blocks;
               w_pt_cnt_nxt  = cfg_pt_blocks;
               w_first_nxt   = 1'b1;
               if (cfg_aad_blocks != '0) begin
                  w_state_nxt = S_AAD;
               end else if (cfg_pt_blocks != '0) begin
                  w_state_nxt = S_PT;
               end else begin
                  // Empty instance: emit a single blank block so a tag is still produced
                  w_state_nxt = S_DONE;
                  w_valid_nxt = 1'b1;
                  w_new_nxt   = 1'b1;
                  w_first_nxt = 1'b0;
               end
            end
         end
         S_AAD: begin
            if (in_valid) begin
               w_valid_nxt = 1'b1;
               w_new_nxt   = r_first;
               w_first_nxt = 1'b0;
               w_aad_nxt   = in_data;
               if (r_aad_cnt != '0) w_aad_cnt_nxt = r_aad_cnt - SIZE_W'(1);
               if (r_aad_cnt <= SIZE_W'(1)) begin
                  w_state_nxt = (r_pt_cnt != '0) ? S_PT : S_DONE;
               end
            end
         end
         S_PT: begin
            if (in_valid) begin
               w_valid_nxt = 1'b1;
               w_new_nxt   = r_first;
               w_first_nxt = 1'b0;
               w_pt_nxt    = 1'b1;
               w_plain_nxt = in_data;
               if (r_pt_cnt != '0) w_pt_cnt_nxt = r_pt_cnt - SIZE_W'(1);
               if (r_pt_cnt <= SIZE_W'(1)) w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, counters, captured config and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_aad_cnt  <= '0;
         r_pt_cnt   <= '0;
         r_first    <= 1'b0;
         r_valid    <= 1'b0;
         r_new      <= 1'b0;
         r_pt       <= 1'b0;
         r_aad      <= '0;
         r_plain    <= '0;
         r_done     <= 1'b0;
         r_key      <= '0;
         r_iv       <= '0;
         r_aad_size <= '0;
         r_pt_size  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_aad_cnt <= w_aad_cnt_nxt;
         r_pt_cnt  <= w_pt_cnt_nxt;
         r_first   <= w_first_nxt;
         r_valid   <= w_valid_nxt;
         r_new     <= w_new_nxt;
         r_pt      <= w_pt_nxt;
         r_aad     <= w_aad_nxt;
         r_plain   <= w_plain_nxt;
         r_done    <= w_done_nxt;
         if (w_cfg_fire) begin
            r_key      <= cfg_key;
            r_iv       <= cfg_iv;
            r_aad_size <= cfg_aad_blocks;
            r_pt_size  <= cfg_pt_blocks;
         end
      end
   end

   assign o_valid           = r_valid;
   assign o_new_instance    = r_new;
   assign o_pt_instance     = r_pt;
   assign o_aad             = r_aad;
   assign o_plain_text      = r_plain;
   assign o_instance_done   = r_done;
   assign o_cipher_key      = r_key;
   assign o_iv              = r_iv;
   assign o_aad_size        = r_aad_size;
   assign o_plain_text_size = r_pt_size;

endmodule
